// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        Zero  = 2'b00,
        Wait0 = 2'b01,
        One   = 2'b10,
        Wait1 = 2'b11
    } state_e;

    // Stability window length M = 2^cnt_w - 1 cycles.
    function automatic int unsigned window_len(int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: input synchroniser, four-state stability FSM, registered ticks.
// Long-press hold counter and hold_tick_o are built only with DEBOUNCE_HOLD_EN.
module debounce_ch #(
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned SYNC_STAGES = 2
`ifdef DEBOUNCE_HOLD_EN
    ,
    parameter int unsigned HOLD_W      = 26
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic db_level_o,
    output logic rise_tick_o,
    output logic fall_tick_o
`ifdef DEBOUNCE_HOLD_EN
    ,
    output logic hold_tick_o
`endif
);
    import debounce_pkg::*;

    localparam logic [CNT_W-1:0] Window = CNT_W'(window_len(CNT_W));
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= Zero;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Terminal test is q==1, so the counter never decrements to 0 inside a wait state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            Zero: begin
                if (s) begin
                    state_d = Wait1;
                    cnt_d   = Window;
                end
            end
            Wait1: begin
                if (!s) begin
                    state_d = Zero;
                end else if (cnt_q == CntOne) begin
                    state_d = One;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            One: begin
                if (!s) begin
                    state_d = Wait0;
                    cnt_d   = Window;
                end
            end
            Wait0: begin
                if (s) begin
                    state_d = One;
                end else if (cnt_q == CntOne) begin
                    state_d = Zero;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = Zero;
        endcase
        level_d = (state_d == One) || (state_d == Wait0);
    end

    assign db_level_o  = level_q;
    assign rise_tick_o = rise_q;
    assign fall_tick_o = fall_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam logic [HOLD_W-1:0] HoldMax = '1;
    localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hold_tick_q, hold_tick_d;

    // Saturating counter fires its tick once, on the step into all-ones.
    always_comb begin
        hold_d      = '0;
        hold_tick_d = 1'b0;
        if (state_q == One) begin
            hold_d      = (hold_q == HoldMax) ? hold_q : hold_q + HoldOne;
            hold_tick_d = (hold_q == HoldMax - HoldOne);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q      <= '0;
            hold_tick_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_tick_q <= hold_tick_d;
        end
    end

    assign hold_tick_o = hold_tick_q;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: CH independent debounce_ch instances.
// Define DEBOUNCE_HOLD_EN to add per-channel long-press hold_tick outputs.
module debounce_multi #(
    parameter int unsigned CH          = 4,
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned SYNC_STAGES = 2
`ifdef DEBOUNCE_HOLD_EN
    ,
    parameter int unsigned HOLD_W      = 26
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick
`ifdef DEBOUNCE_HOLD_EN
    ,
    output logic [CH-1:0] hold_tick
`endif
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCE_HOLD_EN
            ,
            .HOLD_W      (HOLD_W)
`endif
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (reset_n),
            .sw_i        (sw[i]),
            .db_level_o  (db_level[i]),
            .rise_tick_o (rise_tick[i]),
            .fall_tick_o (fall_tick[i])
`ifdef DEBOUNCE_HOLD_EN
            ,
            .hold_tick_o (hold_tick[i])
`endif
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi with CNT_W=4 (M=15), SYNC_STAGES=2, CH=4, HOLD_W=6.
module tb_debounce_multi;

    localparam int Lat  = 18;  // SYNC_STAGES + 1 + M
    localparam int Hold = 63;  // 2^HOLD_W - 1

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sw;
    logic [3:0] db_level, rise_tick, fall_tick, hold_mon;

`ifdef DEBOUNCE_HOLD_EN
    logic [3:0] hold_tick;
    assign hold_mon = hold_tick;
`else
    assign hold_mon = 4'b0000;
`endif

    debounce_multi #(
        .CH          (4),
        .CNT_W       (4),
        .SYNC_STAGES (2)
`ifdef DEBOUNCE_HOLD_EN
        ,
        .HOLD_W      (6)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw        (sw),
        .db_level  (db_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
`ifdef DEBOUNCE_HOLD_EN
        ,
        .hold_tick (hold_tick)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] hold;
        logic [3:0] level;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic expect_evt(input int off, input logic [3:0] r, input logic [3:0] f,
                              input logic [3:0] h, input logic [3:0] l);
        evt_t e;
        e.cyc   = cyc + off;
        e.rise  = r;
        e.fall  = f;
        e.hold  = h;
        e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any tick pops the next expected event; overdue events count as missed.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                check("missed_tick_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
            if ((rise_tick | fall_tick | hold_mon) != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", {20'd0, rise_tick, fall_tick, hold_mon}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("rise_tick", 32'(rise_tick), 32'(mon_e.rise));
                    check("fall_tick", 32'(fall_tick), 32'(mon_e.fall));
                    check("hold_tick", 32'(hold_mon), 32'(mon_e.hold));
                    check("db_level_at_tick", 32'(db_level), 32'(mon_e.level));
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        sw      = 4'b0000;
        wait_cycles(3);
        reset_n = 1'b1;
        check("reset_db_level", 32'(db_level), 32'd0);
        check("reset_rise", 32'(rise_tick), 32'd0);
        check("reset_fall", 32'(fall_tick), 32'd0);
        check("reset_hold", 32'(hold_mon), 32'd0);
        wait_cycles(20);
        check("idle_db_level", 32'(db_level), 32'd0);

        // Clean rise and fall on channel 0.
        sw[0] = 1'b1;
        expect_evt(Lat, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        wait_cycles(25);
        check("ch0_level_high", 32'(db_level), 32'h1);
        sw[0] = 1'b0;
        expect_evt(Lat, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        wait_cycles(25);

        // Channel 1 glitches low mid-window; timing restarts from the last edge.
        sw[1] = 1'b1;
        wait_cycles(10);
        sw[1] = 1'b0;
        wait_cycles(1);
        sw[1] = 1'b1;
        expect_evt(Lat, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        wait_cycles(25);
        sw[1] = 1'b0;
        expect_evt(Lat, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        wait_cycles(25);

        // Channel 2 falls with a 5-cycle bounce back to high.
        sw[2] = 1'b1;
        expect_evt(Lat, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        wait_cycles(25);
        sw[2] = 1'b0;
        wait_cycles(5);
        sw[2] = 1'b1;
        wait_cycles(3);
        check("ch2_level_in_bounce", 32'(db_level), 32'h4);
        sw[2] = 1'b0;
        expect_evt(Lat, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        wait_cycles(25);

        // All channels rise together; hold tick once per press when enabled.
        sw = 4'b1111;
        expect_evt(Lat, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
`ifdef DEBOUNCE_HOLD_EN
        expect_evt(Lat + Hold, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
        wait_cycles(110);
`else
        wait_cycles(25);
`endif
        check("all_level_high", 32'(db_level), 32'hf);
        sw = 4'b0000;
        expect_evt(Lat, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        wait_cycles(25);

        // Reset mid-WAIT1 on channel 3, switch held through reset.
        sw[3] = 1'b1;
        wait_cycles(10);
        reset_n = 1'b0;
        #1;
        check("midreset_level", 32'(db_level), 32'd0);
        check("midreset_rise", 32'(rise_tick), 32'd0);
        wait_cycles(2);
        reset_n = 1'b1;
        expect_evt(Lat, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        wait_cycles(25);
        sw[3] = 1'b0;
        expect_evt(Lat, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        wait_cycles(25);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel switch/button debouncer; next generation of the team's single-channel debounce FSM.
- Adds per-channel input synchronisers, separate registered rise and fall ticks, and a configurable stability window.
- Sits between raw board pins (switches, push-buttons) and the VGA control logic, e.g. mode select and cursor move.
- Each channel runs independently with identical timing.

Parameters:
- CH, 4, number of independent input channels (1..32)
- CNT_W, 21, stability counter width; the stability window is M = 2^CNT_W - 1 cycles
- SYNC_STAGES, 2, flip-flops in each input synchroniser (2..4)
- HOLD_W, 26, long-press counter width; used only when DEBOUNCE_HOLD_EN is defined

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sw  in  CH  raw asynchronous switch inputs
- db_level  out  CH  debounced level per channel
- rise_tick  out  CH  one-cycle pulse when a channel's debounced level goes 0->1
- fall_tick  out  CH  one-cycle pulse when a channel's debounced level goes 1->0
- hold_tick  out  CH  one-cycle long-press pulse; present only with DEBOUNCE_HOLD_EN

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: all synchroniser flops 0; every channel state ZERO; counters 0; db_level, rise_tick, fall_tick and hold_tick all 0.
- Synchroniser: s[i] is sw[i] delayed by SYNC_STAGES flops. The FSM sees only s[i].
- Per-channel FSM has four states:
  - ZERO: if s=1, go to WAIT1 and load q=M.
  - WAIT1: if s=0, return to ZERO (q is don't-care). If s=1 and q==1, go to ONE and register rise_tick=1. Otherwise q=q-1.
  - ONE: if s=0, go to WAIT0 and load q=M.
  - WAIT0: if s=1, return to ONE. If s=0 and q==1, go to ZERO and register fall_tick=1. Otherwise q=q-1.
- Stability window: s must hold the new value for the first cycle plus M cycles in the wait state. Any glitch restarts the window from the stable state.
- db_level:
  - Registered.
  - 1 in ONE and WAIT0; 0 in ZERO and WAIT1.
  - Changes in the same cycle the corresponding tick is high.
- Ticks: registered, exactly one cycle wide, never asserted together on one channel.
- Latency: from sw[i] rising (setup-met) to rise_tick/db_level=1 is SYNC_STAGES + 1 + M cycles.
- Counter: unsigned CNT_W-bit, never wraps. q==1 is the terminal test, so q never reaches 0 while in a wait state.
- Independence:
  - Channels share no state.
  - Simultaneous events on any channels produce simultaneous ticks.
- Reset mid-window: the channel returns to ZERO with db_level=0 and no tick. A switch held high through reset re-debounces from ZERO after reset releases.
- Illegal state encoding: recover to ZERO on the next clock.

Optional Feature:
- Macro: DEBOUNCE_HOLD_EN.
- Defined:
  - Each channel gets an HOLD_W-bit hold counter, cleared whenever the channel is not in ONE.
  - In ONE the counter increments, saturating at all-ones.
  - hold_tick[i] pulses for one cycle when the counter first reaches 2^HOLD_W - 1; it fires once per press.
- Undefined: no hold counter logic and no hold_tick port.

Decomposition:
- Package debounce_pkg holds:
  - the state type: ZERO=2'b00, WAIT0=2'b01, ONE=2'b10, WAIT1=2'b11
  - a function computing M from CNT_W
- Sub-module debounce_ch: one channel containing synchroniser, FSM, counter, ticks and optional hold logic. It is instantiated CH times via generate.

Test Plan (CNT_W=4 so M=15, SYNC_STAGES=2, CH=4, HOLD_W=6):
- Reset release with sw=0 -> all outputs 0; a 20-cycle idle check shows no ticks.
- sw[0] 0->1 held -> rise_tick[0] exactly one cycle, 18 cycles after the edge; db_level[0]=1 the same cycle; other channels unaffected.
- sw[1] high for 10 cycles, low 1 cycle, high again -> no tick until 18 cycles after the final rising edge.
- sw[2] 1->0 from a stable ONE state -> fall_tick[2] 18 cycles later; db_level[2]=0 the same cycle; a 5-cycle bounce resets the window.
- All four channels rise on the same cycle -> rise_tick=4'b1111 in one cycle; reset_n pulsed mid-WAIT1 -> outputs immediately 0, no tick.
- With DEBOUNCE_HOLD_EN, sw[3] held -> hold_tick[3] one pulse 63 cycles after rise_tick[3]; no repeat while held.
